// File: rtl/mem_arb_pkg.sv
// Shared encodings and sizing helpers for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between fetch and data requests, with a data streak
// limiter so a steady data stream cannot starve instruction fetch.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    localparam int unsigned SW = width_for(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    logic [SW-1:0] streak;

    // Data wins unless fetch is waiting and data has used up its streak.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (idle) begin
            if (d_req && !(if_req && (streak == STREAK_MAX))) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Count data grants taken while fetch waits; clear once fetch is served or gone.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (if_gnt || !if_req) begin
            streak <= '0;
        end else if (d_gnt && (streak != STREAK_MAX)) begin
            streak <= streak + SW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between the CPU fetch and data ports.
// One access at a time, strobes held MEM_LAT cycles, one-cycle rvalid pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = width_for(MEM_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    arb_owner_t    owner;
    logic [CW-1:0] cnt;
    logic          idle_c;
    logic          accept_c;
    logic          done_c;

    // Grants are only offered from IDLE and never while reset is asserted.
    assign idle_c = (state == ST_IDLE) && !rst;

    mem_arb_select #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_select (
        .clk    (clk),
        .rst    (rst),
        .idle   (idle_c),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: enter ACCESS on a grant, leave when the latency count runs out.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        done_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_gnt || d_gnt) begin
                    accept_c  = 1'b1;
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    done_c    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Access latches, memory strobes and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_IF;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else if (accept_c) begin
            owner     <= d_gnt ? OWN_D : OWN_IF;
            cnt       <= CNT_LOAD;
            mem_addr  <= d_gnt ? d_addr : if_addr;
            mem_wdata <= d_gnt ? d_wdata : mem_wdata;
            mem_read  <= !(d_gnt && d_we);
            mem_write <= d_gnt && d_we;
        end else if (done_c) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else if ((state == ST_ACCESS) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Completion: capture read data for the owner and pulse its rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata  <= '0;
            if_rvalid <= 1'b0;
            d_rdata   <= '0;
            d_rvalid  <= 1'b0;
        end else begin
            if_rvalid <= done_c && (owner == OWN_IF);
            d_rvalid  <= done_c && (owner == OWN_D);
            if (done_c && !mem_write) begin
                if (owner == OWN_IF) begin
                    if_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut A runs MEM_LAT=1, dut B runs MEM_LAT=3.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_a, rst_b;

    logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic        a_mem_read, a_mem_write;
    logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic        b_mem_read, b_mem_write;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int checks = 0;
    int errors = 0;

    // Memory models: unwritten words read back as 0x5A000000 ^ address.
    bit [31:0] a_wm [0:1023];
    bit        a_wv [0:1023];
    bit [31:0] b_wm [0:1023];
    bit        b_wv [0:1023];

    function automatic logic [31:0] dflt(input logic [31:0] addr);
        return 32'h5A00_0000 ^ addr;
    endfunction

    assign a_mem_rdata = a_wv[a_mem_addr[9:0]] ? a_wm[a_mem_addr[9:0]] : dflt(a_mem_addr);
    assign b_mem_rdata = b_wv[b_mem_addr[9:0]] ? b_wm[b_mem_addr[9:0]] : dflt(b_mem_addr);

    always @(posedge clk) begin
        if (a_mem_write) begin
            a_wm[a_mem_addr[9:0]] <= a_mem_wdata;
            a_wv[a_mem_addr[9:0]] <= 1'b1;
        end
        if (b_mem_write) begin
            b_wm[b_mem_addr[9:0]] <= b_mem_wdata;
            b_wv[b_mem_addr[9:0]] <= 1'b1;
        end
    end

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_DSTREAK(4)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rdata(a_if_rdata), .if_rvalid(a_if_rvalid),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rdata(a_d_rdata), .d_rvalid(a_d_rvalid),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_read(a_mem_read),
        .mem_write(a_mem_write), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_DSTREAK(4)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rdata(b_if_rdata), .if_rvalid(b_if_rvalid),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rdata(b_d_rdata), .d_rvalid(b_d_rvalid),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .mem_rdata(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Strobes must be mutually exclusive on both instances.
    always @(negedge clk) begin
        if (!rst_a) chk("a_strobe_excl", {63'd0, a_mem_read & a_mem_write}, 64'd0);
        if (!rst_b) chk("b_strobe_excl", {63'd0, b_mem_read & b_mem_write}, 64'd0);
    end

    // Requesters must hold their address until granted.
    logic        a_if_pend, a_d_pend;
    logic [31:0] a_if_held, a_d_held;
    always @(posedge clk) begin
        a_if_pend <= a_if_req && !a_if_gnt && !rst_a;
        a_d_pend  <= a_d_req && !a_d_gnt && !rst_a;
        a_if_held <= a_if_addr;
        a_d_held  <= a_d_addr;
    end
    always @(negedge clk) begin
        if (a_if_pend && a_if_req) chk("a_if_addr_stable", a_if_addr, a_if_held);
        if (a_d_pend && a_d_req)   chk("a_d_addr_stable", a_d_addr, a_d_held);
    end

    int          n_gnt;
    logic [5:0]  seq;
    logic [5:0]  seq_exp;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_if_req = 0; a_if_addr = 0; a_d_req = 0; a_d_we = 0; a_d_addr = 0; a_d_wdata = 0;
        b_if_req = 0; b_if_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
        a_if_pend = 0; a_d_pend = 0; a_if_held = 0; a_d_held = 0;
        repeat (3) nxt();
        smp();
        chk("rst_if_gnt", a_if_gnt, 0);
        chk("rst_d_rvalid", a_d_rvalid, 0);
        chk("rst_mem_read", a_mem_read, 0);
        chk("rst_mem_addr", a_mem_addr, 0);
        chk("rst_d_rdata", a_d_rdata, 0);
        nxt(); rst_a = 1'b0; rst_b = 1'b0;

        // 1: single fetch, MEM_LAT=1
        nxt(); a_if_req = 1; a_if_addr = 32'h10;
        smp(); chk("t1_if_gnt", a_if_gnt, 1); chk("t1_d_gnt", a_d_gnt, 0);
        chk("t1_read_pre", a_mem_read, 0);
        nxt(); a_if_req = 0;
        smp(); chk("t1_read", a_mem_read, 1); chk("t1_addr", a_mem_addr, 32'h10);
        chk("t1_rvalid_early", a_if_rvalid, 0);
        nxt();
        smp(); chk("t1_rvalid", a_if_rvalid, 1); chk("t1_rdata", a_if_rdata, 32'h5A00_0010);
        chk("t1_read_off", a_mem_read, 0);
        nxt();
        smp(); chk("t1_rvalid_pulse", a_if_rvalid, 0);

        // 2: simultaneous fetch and data read, data first
        nxt(); a_if_req = 1; a_if_addr = 32'h14; a_d_req = 1; a_d_we = 0; a_d_addr = 32'h200;
        smp(); chk("t2_d_gnt", a_d_gnt, 1); chk("t2_if_gnt_held", a_if_gnt, 0);
        nxt(); a_d_req = 0;
        smp(); chk("t2_read", a_mem_read, 1); chk("t2_addr", a_mem_addr, 32'h200);
        chk("t2_no_gnt_access", a_if_gnt, 0);
        nxt();
        smp(); chk("t2_d_rvalid", a_d_rvalid, 1); chk("t2_d_rdata", a_d_rdata, 32'h5A00_0200);
        chk("t2_if_gnt", a_if_gnt, 1);
        nxt(); a_if_req = 0;
        smp(); chk("t2_if_read", a_mem_read, 1); chk("t2_if_addr", a_mem_addr, 32'h14);
        nxt();
        smp(); chk("t2_if_rvalid", a_if_rvalid, 1); chk("t2_if_rdata", a_if_rdata, 32'h5A00_0014);

        // 3: data write then read-back
        nxt(); a_d_req = 1; a_d_we = 1; a_d_addr = 32'h40; a_d_wdata = 32'hDEAD_BEEF;
        smp(); chk("t3_d_gnt", a_d_gnt, 1);
        nxt(); a_d_req = 0; a_d_we = 0;
        smp(); chk("t3_write", a_mem_write, 1); chk("t3_read", a_mem_read, 0);
        chk("t3_addr", a_mem_addr, 32'h40); chk("t3_wdata", a_mem_wdata, 32'hDEAD_BEEF);
        nxt();
        smp(); chk("t3_rvalid", a_d_rvalid, 1); chk("t3_rdata_kept", a_d_rdata, 32'h5A00_0200);
        chk("t3_write_off", a_mem_write, 0);
        nxt();
        smp(); chk("t3_rvalid_pulse", a_d_rvalid, 0);
        nxt(); a_d_req = 1; a_d_addr = 32'h40;
        smp(); chk("t3_rd_gnt", a_d_gnt, 1);
        nxt(); a_d_req = 0;
        nxt();
        smp(); chk("t3_rd_rvalid", a_d_rvalid, 1); chk("t3_rd_data", a_d_rdata, 32'hDEAD_BEEF);

        // 4: data streak limit with fetch waiting
        nxt(); a_if_req = 1; a_if_addr = 32'h80; a_d_req = 1; a_d_we = 0; a_d_addr = 32'h84;
        n_gnt = 0; seq = '0;
        for (int c = 0; c < 60 && n_gnt < 6; c++) begin
            smp();
            if (a_d_gnt || a_if_gnt) begin
                seq[n_gnt] = a_if_gnt;
                n_gnt++;
            end
            if (n_gnt < 6) nxt();
        end
        chk("t4_grants", n_gnt, 6);
        seq_exp = 6'b01_0000;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t4_gnt%0d_is_if", k), seq[k], seq_exp[k]);
        end
        nxt(); a_if_req = 0; a_d_req = 0;
        repeat (3) nxt();

        // 5: MEM_LAT=3 latency, strobe width, back-to-back grant in rvalid cycle
        nxt(); b_d_req = 1; b_d_we = 0; b_d_addr = 32'h30;
        smp(); chk("t5_d_gnt", b_d_gnt, 1);
        nxt(); b_d_req = 0; b_if_req = 1; b_if_addr = 32'h34;
        for (int k = 1; k <= 3; k++) begin
            smp();
            chk($sformatf("t5_read_c%0d", k), b_mem_read, 1);
            chk($sformatf("t5_rvalid_c%0d", k), b_d_rvalid, 0);
            chk($sformatf("t5_if_wait_c%0d", k), b_if_gnt, 0);
            nxt();
        end
        smp(); chk("t5_read_off", b_mem_read, 0); chk("t5_rvalid", b_d_rvalid, 1);
        chk("t5_rdata", b_d_rdata, 32'h5A00_0030); chk("t5_b2b_if_gnt", b_if_gnt, 1);
        nxt(); b_if_req = 0;
        smp(); chk("t5_if_addr", b_mem_addr, 32'h34);
        repeat (3) nxt();
        smp(); chk("t5_if_rvalid", b_if_rvalid, 1); chk("t5_if_rdata", b_if_rdata, 32'h5A00_0034);

        // 6: reset during the second ACCESS cycle
        nxt(); b_d_req = 1; b_d_addr = 32'h38;
        smp(); chk("t6_d_gnt", b_d_gnt, 1);
        nxt(); b_d_req = 0;
        smp(); chk("t6_read_c1", b_mem_read, 1);
        nxt(); rst_b = 1'b1;
        smp(); chk("t6_read_c2", b_mem_read, 1);
        nxt();
        smp(); chk("t6_read_drop", b_mem_read, 0); chk("t6_rvalid", b_d_rvalid, 0);
        chk("t6_d_rdata", b_d_rdata, 0); chk("t6_if_rdata", b_if_rdata, 0);
        chk("t6_mem_addr", b_mem_addr, 0);
        nxt(); rst_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            smp(); chk($sformatf("t6_no_rvalid%0d", k), b_d_rvalid, 0);
            nxt();
        end
        b_d_req = 1; b_d_addr = 32'h3C;
        smp(); chk("t6_new_gnt", b_d_gnt, 1);
        nxt(); b_d_req = 0;
        repeat (3) nxt();
        smp(); chk("t6_new_rvalid", b_d_rvalid, 1); chk("t6_new_rdata", b_d_rdata, 32'h5A00_003C);

        nxt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
